imm_gen_pipe: RTL and testbench

Registered, handshaked successor to the combinational immediate generator. Decodes every RV64I immediate format (I, S, B, U, J), not only I/S/B. It also reports format and illegal-opcode flags and buffers results in a 2-entry skid buffer with valid/ready flow control and flush. It sits between instruction fetch and decode/execute, so fetch can stall independently of downstream.

---
 rtl/imm_gen_pipe.sv | 148 ++++++++++++++
 tb/tb_imm_gen_pipe.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV64I immediate generator with registered, valid/ready-handshaked output.
// Combinational decode feeds a 2-entry skid buffer (main + skid) with flush.
module imm_gen_pipe #(
  parameter int INSTRSIZE = 32,
  parameter int IMMSIZE   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTRSIZE-1:0] in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTRSIZE-1:0] out_instr,
  output logic [IMMSIZE-1:0]   out_imm,
  output logic [2:0]           out_fmt,
  output logic                 out_illegal
);

  if (INSTRSIZE != 32) begin : g_bad_instrsize
    $error("imm_gen_pipe: INSTRSIZE must be 32");
  end
  if (IMMSIZE < 32 || IMMSIZE > 128) begin : g_bad_immsize
    $error("imm_gen_pipe: IMMSIZE must be within 32..128");
  end

  typedef enum logic [6:0] {
    OPC_OP        = 7'b0110011,
    OPC_OP_32     = 7'b0111011,
    OPC_OP_IMM    = 7'b0010011,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_LOAD      = 7'b0000011,
    OPC_JALR      = 7'b1100111,
    OPC_STORE     = 7'b0100011,
    OPC_BRANCH    = 7'b1100011,
    OPC_LUI       = 7'b0110111,
    OPC_AUIPC     = 7'b0010111,
    OPC_JAL       = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  typedef struct packed {
    logic                 valid;
    logic [INSTRSIZE-1:0] instr;
    logic [IMMSIZE-1:0]   imm;
    fmt_e                 fmt;
    logic                 illegal;
  } entry_t;

  entry_t             dec;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic signed [31:0] imm32;
  logic               drain;
  logic               accept;

  // Every format fits in 32 bits; one signed widening covers all IMMSIZE values.
  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    dec.instr = in_instr;
    imm32     = '0;
    case (in_instr[6:0])
      OPC_OP, OPC_OP_32: begin
        dec.fmt = FMT_R;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
        dec.fmt = FMT_I;
        imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OPC_STORE: begin
        dec.fmt = FMT_S;
        imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec.fmt = FMT_B;
        imm32   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.fmt = FMT_U;
        imm32   = {in_instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        dec.fmt = FMT_J;
        imm32   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
      end
      default: begin
        dec.fmt     = FMT_ILL;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = IMMSIZE'(imm32);
  end

  assign in_ready  = !skid_q.valid;
  assign drain     = !main_q.valid || out_ready;
  assign accept    = in_valid && !skid_q.valid;

  // Flush wins; otherwise a full skid always refills main before new input is taken.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d.valid = 1'b0;
      skid_d.valid = 1'b0;
    end else if (drain) begin
      if (skid_q.valid) begin
        main_d       = skid_q;
        skid_d.valid = 1'b0;
      end else if (accept) begin
        main_d = dec;
      end else begin
        main_d.valid = 1'b0;
      end
    end else if (accept) begin
      skid_d = dec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_valid   = main_q.valid;
  assign out_instr   = main_q.instr;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: directed scenarios plus a randomized
// stream scored against a queue model of the buffered instructions.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_imm;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.INSTRSIZE(32), .IMMSIZE(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal)
  );

  // Reference: each immediate built as an integer sum of field weights,
  // with the sign bit contributing its negative weight.
  function automatic void ref_dec(input logic [31:0] w, output logic [63:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    longint v;
    v   = 0;
    fmt = 3'd0;
    ill = 1'b0;
    case (w[6:0])
      7'b0110011, 7'b0111011: fmt = 3'd0;
      7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111: begin
        fmt = 3'd1;
        v = longint'(w[30:20]) - (w[31] ? 64'sd2048 : 64'sd0);
      end
      7'b0100011: begin
        fmt = 3'd2;
        v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - (w[31] ? 64'sd2048 : 64'sd0);
      end
      7'b1100011: begin
        fmt = 3'd3;
        v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2
            - (w[31] ? 64'sd4096 : 64'sd0);
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4;
        v = longint'(w[30:12]) * 4096 - (w[31] ? 64'sd2147483648 : 64'sd0);
      end
      7'b1101111: begin
        fmt = 3'd5;
        v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2
            - (w[31] ? 64'sd1048576 : 64'sd0);
      end
      default: begin
        fmt = 3'd7;
        ill = 1'b1;
      end
    endcase
    imm = 64'(v);
  endfunction

  // Drives one cycle and advances the queue model; checks happen in the callers.
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    bit in_fire, out_fire;
    in_valid  = v;
    in_instr  = w;
    out_ready = ordy;
    flush     = fl;
    in_fire   = v && (model_q.size() < 2);
    out_fire  = ordy && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (fl) model_q.delete();
    else begin
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    #12;
    n_checks++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_instr !== 32'd0 ||
        out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b imm=%h instr=%h fmt=%0d ill=%b, want all zero",
               out_valid, out_imm, out_instr, out_fmt, out_illegal);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_addi();
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 64'hFFFFFFFFFFFFFFFF || out_fmt !== 3'd1 ||
        out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL addi: valid=%b imm=%h fmt=%0d ill=%b, want 1 ffffffffffffffff 1 0",
               out_valid, out_imm, out_fmt, out_illegal);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[4];
    logic [63:0] imms[4];
    logic [2:0]  fmts[4];
    words = '{32'hFE20AE23, 32'h00000463, 32'h800002B7, 32'hFFDFF06F};
    imms  = '{64'hFFFFFFFFFFFFFFFC, 64'd8, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC};
    fmts  = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, words[i], 1'b1, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || out_instr !== words[i] || out_imm !== imms[i] ||
          out_fmt !== fmts[i] || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b[%0d]: valid=%b instr=%h imm=%h fmt=%0d rdy=%b, want 1 %h %h %0d 1",
                 i, out_valid, out_instr, out_imm, out_fmt, in_ready, words[i], imms[i], fmts[i]);
      end
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    cycle(1'b1, 32'h0000007F, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_fmt !== 3'd7 || out_illegal !== 1'b1 ||
        out_imm !== 64'd0 || out_instr !== 32'h0000007F) begin
      n_fail++;
      $display("FAIL illegal: valid=%b fmt=%0d ill=%b imm=%h instr=%h, want 1 7 1 0 0000007f",
               out_valid, out_fmt, out_illegal, out_imm, out_instr);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c;
    a = 32'h00100093; b = 32'h00200113; c = 32'h00300193;
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_instr !== a || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b instr=%h valid=%b, want 0 %h 1", in_ready, out_instr, out_valid, a);
    end
    cycle(1'b1, c, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || out_instr !== a || out_imm !== 64'd1) begin
      n_fail++;
      $display("FAIL bp_hold: rdy=%b instr=%h imm=%h, want 0 %h 1", in_ready, out_instr, out_imm, a);
    end
    cycle(1'b1, c, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== b || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: valid=%b instr=%h rdy=%b, want 1 %h 1", out_valid, out_instr, in_ready, b);
    end
    cycle(1'b1, c, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== c || out_imm !== 64'd3) begin
      n_fail++;
      $display("FAIL bp_third: valid=%b instr=%h imm=%h, want 1 %h 3", out_valid, out_instr, out_imm, c);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    cycle(1'b1, 32'h00500293, 1'b0, 1'b0);
    cycle(1'b1, 32'h00600313, 1'b0, 1'b0);
    cycle(1'b1, 32'h00700393, 1'b0, 1'b1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush: valid=%b rdy=%b, want 0 1", out_valid, in_ready);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_discard: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 32'h00800413, 1'b0, 1'b0);
    cycle(1'b1, 32'h00900493, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_imm !== 64'd0 || out_instr !== 32'd0 ||
        out_fmt !== 3'd0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b imm=%h instr=%h fmt=%0d ill=%b, want all zero",
               out_valid, out_imm, out_instr, out_fmt, out_illegal);
    end
    @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_rdy: got %b want 1", in_ready);
    end
    cycle(1'b1, 32'hFFF00093, 1'b1, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_instr !== 32'hFFF00093 || out_imm !== 64'hFFFFFFFFFFFFFFFF) begin
      n_fail++;
      $display("FAIL async_reset_after: valid=%b instr=%h imm=%h, want 1 fff00093 ffffffffffffffff",
               out_valid, out_instr, out_imm);
    end
    cycle(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]  opcs[11];
    logic [31:0] w;
    logic [63:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    opcs = '{7'b0110011, 7'b0111011, 7'b0010011, 7'b0011011, 7'b0000011, 7'b1100111,
             7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    for (int n = 0; n < 2000; n++) begin
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 10)];
      cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      n_checks++;
      if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2)) begin
        n_fail++;
        $display("FAIL rand_flags[%0d]: valid=%b rdy=%b, want %b %b", n, out_valid, in_ready,
                 model_q.size() > 0, model_q.size() < 2);
      end
      if (model_q.size() > 0) begin
        ref_dec(model_q[0], e_imm, e_fmt, e_ill);
        n_checks++;
        if (out_instr !== model_q[0] || out_imm !== e_imm || out_fmt !== e_fmt ||
            out_illegal !== e_ill) begin
          n_fail++;
          $display("FAIL rand_data[%0d]: instr=%h imm=%h fmt=%0d ill=%b, want %h %h %0d %b",
                   n, out_instr, out_imm, out_fmt, out_illegal, model_q[0], e_imm, e_fmt, e_ill);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
